uart_rx: RTL and testbench

- Receive-side counterpart of the team's UART transmitter. Consumes the serial line produced by the TX top and rebuilds the byte.
- Frame format: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- Runs on the same CLK at PRESCALE samples per bit. Delivers P_DATA with a one-cycle DATA_VALID pulse plus error flags.

---
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_rx.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: the serial line and frame config in, the rebuilt byte and status pulses out.
// The DUT connects through "slave"; whatever drives the line and consumes the byte uses "master".
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_WIDTH data bits LSB first, optional parity, 1 stop, PRESCALE clocks per bit.
// Define UART_RX_MAJORITY_EN to vote three samples around mid-bit instead of taking a single sample.
module uart_rx #(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input logic     CLK,
  input logic     RST,
  uart_rx_if.slave bus
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(PRESCALE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [EW-1:0] SAMPLE_AT = EW'(PRESCALE / 2 + 1);
  localparam logic [EW-1:0] VOTE_A_AT = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] VOTE_B_AT = EW'(PRESCALE / 2);
`else
  localparam logic [EW-1:0] SAMPLE_AT = EW'(PRESCALE / 2);
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  rx_meta;
  logic                  rx_s;
  logic                  bit_val;
  logic [EW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_en_l;
  logic                  par_typ_l;
  logic                  par_bad;
  logic                  at_sample;
  logic                  at_wrap;
  logic                  latch_cfg;
  logic                  shift_en;
  logic                  par_chk;
  logic                  stop_done;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  // The line is asynchronous to our clock; both flops idle high like the line itself.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.RX_IN;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic vote_a;
  logic vote_b;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else begin
      if (edge_cnt == VOTE_A_AT) vote_a <= rx_s;
      if (edge_cnt == VOTE_B_AT) vote_b <= rx_s;
    end
  end

  assign bit_val = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign at_sample = (edge_cnt == SAMPLE_AT);
  assign at_wrap   = (edge_cnt == LAST_EDGE);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    latch_cfg  = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    stop_done  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) next_state = START;
      end
      START: begin
        if (at_sample && bit_val) begin
          next_state = IDLE;
        end else begin
          latch_cfg = at_sample;
          if (at_wrap) next_state = DATA;
        end
      end
      DATA: begin
        shift_en = at_sample;
        if (at_wrap && (bit_cnt == LAST_BIT)) next_state = par_en_l ? PARITY : STOP;
      end
      PARITY: begin
        par_chk = at_sample;
        if (at_wrap) next_state = STOP;
      end
      STOP: begin
        // Leave on the sample itself so a start bit right behind the stop bit is not missed.
        stop_done = at_sample;
        if (at_sample) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state == IDLE || next_state == IDLE || at_wrap) edge_cnt <= '0;
      else                                                edge_cnt <= edge_cnt + EW'(1);

      if (state != DATA)  bit_cnt <= '0;
      else if (at_wrap)   bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_reg <= '0;
      par_en_l  <= 1'b0;
      par_typ_l <= 1'b0;
      par_bad   <= 1'b0;
    end else begin
      if (latch_cfg) begin
        par_en_l  <= bus.PAR_EN;
        par_typ_l <= bus.PAR_TYP;
        par_bad   <= 1'b0;
      end
      if (shift_en) shift_reg[bit_cnt] <= bit_val;
      // Expected parity bit is XOR of the data, inverted for odd parity.
      if (par_chk)  par_bad <= (bit_val != ((^shift_reg) ^ par_typ_l));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (stop_done) begin
        if (!bit_val) begin
          stp_err <= 1'b1;
        end else if (par_en_l && par_bad) begin
          par_err <= 1'b1;
        end else begin
          data_valid <= 1'b1;
          p_data     <= shift_reg;
        end
      end
    end
  end

  assign bus.P_DATA     = p_data;
  assign bus.DATA_VALID = data_valid;
  assign bus.PAR_ERR    = par_err;
  assign bus.STP_ERR    = stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed frames go out on the line while a separate monitor compares every status pulse
// against the expected event, byte and arrival cycle queued by the stimulus.
module tb_uart_rx;

  localparam int P  = 8;
  localparam int DW = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT_EXTRA = 1;
`else
  localparam int LAT_EXTRA = 0;
`endif

  typedef enum logic [2:0] {
    EV_VALID = 3'b100,
    EV_PAR   = 3'b010,
    EV_STP   = 3'b001
  } ev_t;

  typedef struct {
    ev_t         kind;
    logic [7:0]  data;
    int          when;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];
  logic [7:0] last_good = 8'h00;
  logic [2:0] flags;
  exp_t       head;

  uart_rx_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx #(.PRESCALE(P), .DATA_WIDTH(DW)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual === required) passes++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, required, cyc);
  endtask

  // Monitor: a pulse must match the head of the queue; an overdue head counts as a missing pulse.
  always @(negedge CLK) begin
    if (!RST) begin
      flags = {bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR};
      if (sb.size() > 0 && sb[0].when < cyc) begin
        checkOutput("pulse_missing", 32'(cyc), 32'(sb[0].when));
        void'(sb.pop_front());
      end
      if (flags != 3'b000) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_flags", 32'(flags), 32'd0);
        end else begin
          head = sb.pop_front();
          checkOutput("flag_kind", 32'(flags), 32'(head.kind));
          checkOutput("p_data", 32'(bus.P_DATA), 32'(head.data));
          checkOutput("latency", 32'(cyc), 32'(head.when));
        end
      end
    end
  end

  task automatic driveBit(input logic b);
    bus.RX_IN = b;
    repeat (P) @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    bus.RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Sends one frame; the config inputs are flipped after the start bit and must not matter.
  task automatic applyStimulus(input logic [7:0] data, input logic par_en, input logic par_typ,
                               input logic par_bit, input logic stop_bit, input ev_t kind);
    exp_t e;
    int   stop_idx;
    stop_idx = par_en ? 10 : 9;
    e.kind = kind;
    e.data = (kind == EV_VALID) ? data : last_good;
    e.when = cyc + 4 + P / 2 + P * stop_idx + LAT_EXTRA;
    if (kind == EV_VALID) last_good = data;
    sb.push_back(e);
    bus.PAR_EN  = par_en;
    bus.PAR_TYP = par_typ;
    driveBit(1'b0);
    bus.PAR_EN  = ~par_en;
    bus.PAR_TYP = ~par_typ;
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    if (par_en) driveBit(par_bit);
    driveBit(stop_bit);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_p_data"},     32'(bus.P_DATA),     32'd0);
    checkOutput({tag, "_data_valid"}, 32'(bus.DATA_VALID), 32'd0);
    checkOutput({tag, "_par_err"},    32'(bus.PAR_ERR),    32'd0);
    checkOutput({tag, "_stp_err"},    32'(bus.STP_ERR),    32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] abort_data;
    bus.RX_IN   = 1'b1;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checkResetOutputs("reset");
    RST = 1'b0;
    idle(10);

    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, EV_VALID);
    idle(12);

    applyStimulus(8'h37, 1'b1, 1'b0, 1'b1, 1'b1, EV_VALID);
    idle(12);
    applyStimulus(8'h37, 1'b1, 1'b0, 1'b0, 1'b1, EV_PAR);
    idle(12);

    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, EV_STP);
    idle(20);

    bus.RX_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    idle(20);
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, EV_VALID);
    idle(12);

    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, EV_VALID);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, EV_VALID);
    idle(12);

    abort_data = 8'hC3;
    bus.PAR_EN = 1'b0;
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(abort_data[i]);
    bus.RX_IN = abort_data[4];
    repeat (4) @(posedge CLK);
    #1;
    RST = 1'b1;
    bus.RX_IN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checkResetOutputs("mid_frame_reset");
    RST = 1'b0;
    last_good = 8'h00;
    idle(20);
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, EV_VALID);
    idle(40);

    checkOutput("queue_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
